// File: rtl/crop_filter_pkg.sv
// Shared types and default frame/window sizes for the crop stage and the
// downstream normalizer.
package crop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned PIXEL_BIT_WIDTH = 10;
  localparam int unsigned IN_ROWS         = 64;
  localparam int unsigned IN_COLS         = 64;
  localparam int unsigned OUT_ROWS        = 10;
  localparam int unsigned OUT_COLS        = 10;

endpackage

// File: rtl/crop_filter_if.sv
// Pixel stream bundle: upstream input stream plus cropped output stream.
// The slave modport is the filter side, the master modport the environment side.
interface crop_filter_if #(
  parameter int unsigned PIXEL_BIT_WIDTH = 10
);

  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata;
  logic                       s_axis_tuser;
  logic                       m_axis_tvalid;
  logic                       m_axis_tready;
  logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

endinterface

// File: rtl/crop_filter_axis_out_reg.sv
// Single-entry output register (data + last) with valid/ready; accepts a new
// beat in the same cycle the held one is taken.
module axis_out_reg #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  assign in_ready_c = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready_c) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/crop_filter.sv
// Frame-window cropper: forwards the OUT_ROWS x OUT_COLS window at a clamped
// offset of an IN_ROWS x IN_COLS raster stream and tracks the window maximum.
module crop_filter #(
  parameter int unsigned PIXEL_BIT_WIDTH = crop_pkg::PIXEL_BIT_WIDTH,
  parameter int unsigned IN_ROWS         = crop_pkg::IN_ROWS,
  parameter int unsigned IN_COLS         = crop_pkg::IN_COLS,
  parameter int unsigned OUT_ROWS        = crop_pkg::OUT_ROWS,
  parameter int unsigned OUT_COLS        = crop_pkg::OUT_COLS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_ready,
  output logic                         ap_idle,
  input  logic [$clog2(IN_ROWS)-1:0]   row_offset,
  input  logic [$clog2(IN_COLS)-1:0]   col_offset,
  output logic [PIXEL_BIT_WIDTH-1:0]   max_pixel,
  output logic                         frame_err,
  crop_filter_if.slave                 io
);

  import crop_pkg::*;

  localparam int unsigned RW      = $clog2(IN_ROWS);
  localparam int unsigned CW      = $clog2(IN_COLS);
  localparam int unsigned RW1     = RW + 1;
  localparam int unsigned CW1     = CW + 1;
  localparam int unsigned ROW_MAX = IN_ROWS - OUT_ROWS;
  localparam int unsigned COL_MAX = IN_COLS - OUT_COLS;

  state_t                     state;
  logic [RW-1:0]              row_lat, in_row, eff_row;
  logic [CW-1:0]              col_lat, in_col, eff_col;
  logic                       active_c, take_c, restart_c, in_win_c, win_last_c, at_end_c;
  logic                       or_ready_c, or_valid;
  logic [PIXEL_BIT_WIDTH-1:0] or_data;
  logic                       or_last;

  assign ap_ready = (state == IDLE);
  assign ap_idle  = (state == IDLE);

  // A SOF beat is always pixel (0,0), whether it opens the frame or resyncs it.
  always_comb begin
    io.s_axis_tready = 1'b0;
    case (state)
      SYNC:    io.s_axis_tready = 1'b1;
      RUN:     io.s_axis_tready = or_ready_c;
      default: io.s_axis_tready = 1'b0;
    endcase
    eff_row    = io.s_axis_tuser ? '0 : in_row;
    eff_col    = io.s_axis_tuser ? '0 : in_col;
    take_c     = io.s_axis_tvalid && io.s_axis_tready;
    active_c   = (state == RUN) || ((state == SYNC) && io.s_axis_tuser);
    restart_c  = (state == RUN) && io.s_axis_tuser && ((in_row != '0) || (in_col != '0));
    in_win_c   = (eff_row >= row_lat) && (RW1'(eff_row) < RW1'(row_lat) + RW1'(OUT_ROWS)) &&
                 (eff_col >= col_lat) && (CW1'(eff_col) < CW1'(col_lat) + CW1'(OUT_COLS));
    win_last_c = (eff_row == row_lat + RW'(OUT_ROWS - 1)) &&
                 (eff_col == col_lat + CW'(OUT_COLS - 1));
    at_end_c   = (eff_row == RW'(IN_ROWS - 1)) && (eff_col == CW'(IN_COLS - 1));
  end

  axis_out_reg #(.W(PIXEL_BIT_WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (take_c && active_c && in_win_c),
    .in_ready_c(or_ready_c),
    .in_data   (io.s_axis_tdata),
    .in_last   (win_last_c),
    .out_valid (or_valid),
    .out_ready (io.m_axis_tready),
    .out_data  (or_data),
    .out_last  (or_last)
  );

  assign io.m_axis_tvalid = or_valid;
  assign io.m_axis_tdata  = or_data;
  assign io.m_axis_tlast  = or_last;

  // Control FSM with frame counters, window maximum and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ap_done   <= 1'b0;
      max_pixel <= '0;
      frame_err <= 1'b0;
      row_lat   <= '0;
      col_lat   <= '0;
      in_row    <= '0;
      in_col    <= '0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ap_start) begin
            state     <= SYNC;
            row_lat   <= (row_offset > RW'(ROW_MAX)) ? RW'(ROW_MAX) : row_offset;
            col_lat   <= (col_offset > CW'(COL_MAX)) ? CW'(COL_MAX) : col_offset;
            max_pixel <= '0;
            frame_err <= 1'b0;
            in_row    <= '0;
            in_col    <= '0;
          end
        end
        SYNC, RUN: begin
          if (take_c && active_c) begin
            state <= at_end_c ? DRAIN : RUN;
            if (eff_col == CW'(IN_COLS - 1)) begin
              in_col <= '0;
              in_row <= eff_row + RW'(1);
            end else begin
              in_col <= eff_col + CW'(1);
              in_row <= eff_row;
            end
            if (restart_c) begin
              frame_err <= 1'b1;
              max_pixel <= in_win_c ? io.s_axis_tdata : '0;
            end else if (in_win_c && (io.s_axis_tdata > max_pixel)) begin
              max_pixel <= io.s_axis_tdata;
            end
          end
        end
        DRAIN: begin
          if (!or_valid) begin
            state   <= DONE;
            ap_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crop_filter.md
# crop_filter

Frame-window cropper that feeds the normalization stage. Consumes a full IN_ROWS×IN_COLS pixel stream, forwards only the OUT_ROWS×OUT_COLS window at a programmable offset, and tracks the window's maximum pixel value. On completion it pulses `ap_done`, which drives the downstream normalizer's `cf_ap_done`. The captured maximum drives the normalizer's `norm_denominator`.

## Interface
- PIXEL_BIT_WIDTH, 10, pixel width
- IN_ROWS, 64, input frame rows
- IN_COLS, 64, input frame columns
- OUT_ROWS, 10, crop window rows (≤ IN_ROWS)
- OUT_COLS, 10, crop window columns (≤ IN_COLS)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ap_start  in  1  start one frame; honoured only in IDLE
- ap_done  out  1  one-cycle pulse at frame completion
- ap_ready  out  1  high in IDLE
- ap_idle  out  1  high in IDLE
- row_offset  in  $clog2(IN_ROWS)  window top row; sampled at accepted ap_start
- col_offset  in  $clog2(IN_COLS)  window left column; sampled at accepted ap_start
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel, raster order
- s_axis_tuser  in  1  start-of-frame marker on pixel (0,0)
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake
- m_axis_tdata  out  PIXEL_BIT_WIDTH  cropped pixel
- m_axis_tlast  out  1  marks last window pixel
- max_pixel  out  PIXEL_BIT_WIDTH  window maximum; stable from ap_done until next accepted ap_start
- frame_err  out  1  sticky; set on unexpected SOF; cleared by reset or accepted ap_start

## Operation
- FSM states and transitions:
  - IDLE → SYNC on ap_start.
  - SYNC → RUN on an accepted beat with tuser=1.
  - RUN → DRAIN after the beat at (IN_ROWS-1, IN_COLS-1) is accepted.
  - DRAIN → DONE once the output register is empty.
  - DONE → IDLE unconditionally.
- At accepted ap_start, latch offsets with clamping: row_offset > IN_ROWS-OUT_ROWS clamps to IN_ROWS-OUT_ROWS; the same rule applies to columns. Clear max_pixel to 0, frame_err to 0, and the counters.
- SYNC: s_axis_tready=1. Beats with tuser=0 are discarded. The tuser=1 beat is processed as pixel (0,0).
- RUN: s_axis_tready = !out_valid || m_axis_tready, where out_valid is the output register's valid state. This applies to in-window and out-of-window beats alike, to keep ordering simple.
- Counters: in_col wraps at IN_COLS-1 and increments in_row. No tlast is used on input.
- A pixel is in-window when row_lat ≤ in_row < row_lat+OUT_ROWS and col_lat ≤ in_col < col_lat+OUT_COLS. In-window pixels load the output register and update max_pixel (unsigned compare). Out-of-window pixels are dropped.
- m_axis_tlast = 1 when the loaded pixel is window position (OUT_ROWS-1, OUT_COLS-1).
- tuser=1 in RUN at any position other than (0,0) → frame_err set; max_pixel cleared; counters restart with this beat as (0,0). An output beat already in the register is still delivered.
- In IDLE and DONE: s_axis_tready=0.
- ap_start outside IDLE is ignored.

## Timing
- Reset values: ap_done=0, ap_ready=1, ap_idle=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, max_pixel=0, frame_err=0, FSM=IDLE.
- Reset mid-frame aborts immediately. The held output beat is discarded and no ap_done is generated.
- Latency: an in-window pixel accepted in cycle N is presented on m_axis in cycle N+1. m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
- Full throughput: one pixel per cycle while m_axis_tready=1.
- ap_done is asserted exactly one cycle, in DONE. This is the cycle after the output register empties, or the cycle after DRAIN is entered if it is already empty. max_pixel is final no later than the ap_done cycle.
- ap_ready and ap_idle drop the cycle after an accepted ap_start.

## Structure
- Package crop_pkg: FSM state enum (IDLE, SYNC, RUN, DRAIN, DONE) and the IN/OUT size localparams used by the normalization stage. Downstream sizing (OUT_ROWS, OUT_COLS) is shared from this package.
- One natural sub-module: axis_out_reg. It is the single-entry output register carrying tdata and tlast, with valid/ready.

## Test plan
- IN 8×8, OUT 3×3, offsets (2,4), frame pixel value = 8·row+col, m_axis_tready=1 → 9 beats: 20,21,22,28,29,30,36,37,38; tlast on 38; max_pixel=38; a single ap_done pulse.
- Same setup with m_axis_tready toggled randomly at 50% → identical beat sequence, no drops or duplicates, tdata stable under stall.
- Offsets (7,7) with OUT 3×3 → clamped to (5,5); first beat 45, last beat 63, max_pixel=63.
- Three tuser=0 beats before SOF → discarded; the window output equals that of the clean frame.
- Second tuser=1 at pixel (4,1) → frame_err=1; counting restarts; the frame completes 64 beats after the restart; max_pixel reflects only the restarted frame.
- Reset asserted mid-RUN → next cycle all outputs hold their reset values; a new ap_start plus a full frame yields the correct 9-beat result.
